pong_score_keeper: RTL
======================

# pong_score_keeper

Synchronous, parametrised score keeper for the two-player LED pong game: it conditions the raw player pushbuttons, judges each press as a valid return or a foul, keeps both scores, steers ball direction, and ends the game on a configurable win rule. It sits between the pushbutton pins / LED ball-position logic and the seven-segment decoders, which consume `score_l` / `score_r` directly.

## Interface
- `WIN_SCORE`, 9: points needed to win. Legal range is 1 to 2^SCORE_W-1.
- `SCORE_W`, 4: width of each score register.
- `DEBOUNCE_CYC`, 16: stable cycles required before a button level is accepted. Minimum is 1.

- `clk`  in  1  system clock
- `rst`  in  1  asynchronous, active-high reset
- `btn_l`  in  1  raw left pushbutton, active-low, asynchronous to `clk`
- `btn_r`  in  1  raw right pushbutton, active-low, asynchronous to `clk`
- `ball_at_l`  in  1  ball is on the left-most LED (synchronous)
- `ball_at_r`  in  1  ball is on the right-most LED (synchronous)
- `new_game`  in  1  single-cycle pulse that clears scores and restarts play
- `score_l`  out  SCORE_W  left player score
- `score_r`  out  SCORE_W  right player score
- `dir`  out  1  ball direction: 0 = toward left, 1 = toward right
- `hit`  out  1  one-cycle pulse on each valid return
- `foul`  out  1  one-cycle pulse on each foul
- `game_over`  out  1  high while in the OVER state
- `winner`  out  1  0 = left, 1 = right; valid only while `game_over` = 1

## Operation
- **Button conditioning, per button:**
  - A 2-FF synchroniser feeds a stability counter.
  - The accepted level updates only after the synchronised level has differed from it for DEBOUNCE_CYC consecutive cycles.
  - A press event is an accepted 1→0 transition.
  - Each debouncer resets to accepted = 1 with counter = 0.
- **Judging, PLAY state only:**
  - Left press with `ball_at_l` = 1 is a valid return: `score_l` +1, `dir` ← 1, `hit` pulses.
  - Left press with `ball_at_l` = 0 is a foul: `score_r` +1, `foul` pulses, `dir` unchanged.
  - Right presses are judged symmetrically: valid return → `score_r` +1, `dir` ← 0; foul → `score_l` +1.
  - If both press events occur in the same cycle, only the left event is processed and the right event is discarded.
- **States:**
  - PLAY → OVER when the post-update scores satisfy the win rule. `winner` ← the side whose score just incremented.
  - In OVER, all press events are ignored. Scores, `dir` and `winner` hold.
  - `new_game` in any state → PLAY, both scores = 0, `dir` = 1, `winner` = 0.
  - If `new_game` and a press event occur in the same cycle, `new_game` wins and the press is discarded.
- **Win rule, default build:** game over when a score reaches WIN_SCORE.
- **Arithmetic:**
  - Scores are unsigned SCORE_W.
  - An increment that would wrap past 2^SCORE_W-1 cannot occur. Reaching 2^SCORE_W-1 always forces OVER with the scorer as winner, in every build.

## Timing
- **Reset values:**
  - `score_l` = `score_r` = 0
  - `dir` = 1
  - `hit` = `foul` = 0
  - `game_over` = 0
  - `winner` = 0
  - state = PLAY
- **Press latency:** `btn` is sampled low at edge k and held stable. The press event is internal at edge k+2+DEBOUNCE_CYC. Score, `dir`, `hit`/`foul` and `game_over` are registered at edge k+3+DEBOUNCE_CYC.
- **Glitches:** a glitch shorter than DEBOUNCE_CYC cycles produces no event.
- **Ball position:** `ball_at_l` / `ball_at_r` are sampled in the cycle the press event is internal.
- **Pulse width:** `hit` and `foul` are exactly one cycle wide. At most one of them is high in any cycle.
- **Reset mid-operation:** `rst` asserted mid-debounce clears the counters and discards any pending event. No event is generated on release even if the button is still held; the button must go high and then low again.

## Configuration
- `PONG_WIN_BY_TWO_EN`
  - **Defined:** game over requires score ≥ WIN_SCORE **and** a lead over the opponent of at least 2. The saturation rule at 2^SCORE_W-1 still applies.
  - **Undefined:** first to WIN_SCORE wins, with no margin requirement.

## Test plan
- **Debounce:** WIN_SCORE = 9, DEBOUNCE_CYC = 4. A 3-cycle low glitch on `btn_l` → no `hit`/`foul`. An 8-cycle low with `ball_at_l` = 1 → `hit` exactly 7 cycles after the first low sample, `score_l` = 1, `dir` = 1.
- **Foul:** `btn_r` press with `ball_at_r` = 0 → `foul` pulse, `score_l` +1, `score_r` and `dir` unchanged.
- **Default win:** nine valid left returns → `game_over` = 1, `winner` = 0, `score_l` = 9. Further presses on either button → no score change. `new_game` → scores 0, `game_over` = 0.
- **Simultaneous presses:** both buttons' press events in the same cycle with `ball_at_l` = 1 → only `score_l` increments, one `hit` pulse.
- **Win-by-two** (macro defined, WIN_SCORE = 9):
  - At 9–8, a left point gives 10–8 → OVER, `winner` = 0.
  - Separately, at 8–8, a right point gives 8–9 → still PLAY.
  - With SCORE_W = 4, reaching 15 on either side forces OVER.
- **Reset mid-operation:** assert `rst` while `btn_l` is held low mid-debounce at score 5–3 → all outputs return to their reset values and no event occurs after `rst` deasserts until `btn_l` is released and pressed again.

Source files
------------

// File: rtl/pong_score_keeper.sv
// Two-player LED pong score keeper: debounces both buttons, judges returns/fouls,
// keeps scores and ball direction. Define PONG_WIN_BY_TWO_EN to require a 2-point lead.

module pong_debounce #(
  parameter int DEBOUNCE_CYC = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_n,
  output logic press
);
  localparam int CW = $clog2(DEBOUNCE_CYC + 1);

  logic          meta_q, sync_q;
  logic          acc_q, acc_d;
  logic          armed_q, armed_d;
  logic          press_q, press_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          differ, accept;

  // Synchroniser resets to "pressed" and the arm flag stays clear until a real
  // high level is sampled, so a button held through reset never yields an event.
  always_comb begin
    differ  = (sync_q != acc_q);
    accept  = differ && (cnt_q == CW'(DEBOUNCE_CYC));
    cnt_d   = '0;
    if (differ && !accept) cnt_d = cnt_q + 1'b1;
    acc_d   = accept ? sync_q : acc_q;
    armed_d = armed_q | sync_q;
    press_d = accept & ~sync_q & armed_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q  <= 1'b0;
      sync_q  <= 1'b0;
      acc_q   <= 1'b1;
      cnt_q   <= '0;
      armed_q <= 1'b0;
      press_q <= 1'b0;
    end else begin
      meta_q  <= btn_n;
      sync_q  <= meta_q;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      armed_q <= armed_d;
      press_q <= press_d;
    end
  end

  assign press = press_q;
endmodule

module pong_score_keeper #(
  parameter int WIN_SCORE    = 9,
  parameter int SCORE_W      = 4,
  parameter int DEBOUNCE_CYC = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               btn_l,
  input  logic               btn_r,
  input  logic               ball_at_l,
  input  logic               ball_at_r,
  input  logic               new_game,
  output logic [SCORE_W-1:0] score_l,
  output logic [SCORE_W-1:0] score_r,
  output logic               dir,
  output logic               hit,
  output logic               foul,
  output logic               game_over,
  output logic               winner
);
  localparam int NUM_LANES = 2;  // lane 0 = left, lane 1 = right

  typedef enum logic {PLAY, OVER} state_e;

  logic [NUM_LANES-1:0] btn_raw, press;
  assign btn_raw = {btn_r, btn_l};

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_db
    pong_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db (
      .clk   (clk),
      .rst   (rst),
      .btn_n (btn_raw[i]),
      .press (press[i])
    );
  end

  state_e             state_q, state_d;
  logic [SCORE_W-1:0] sl_q, sl_d, sr_q, sr_d;
  logic               dir_q, dir_d, win_q, win_d;
  logic               hit_q, hit_d, foul_q, foul_d;
  logic               scorer, rule_met, sat;
  logic [SCORE_W:0]   s_w, o_w;

  always_comb begin
    state_d  = state_q;
    sl_d     = sl_q;
    sr_d     = sr_q;
    dir_d    = dir_q;
    win_d    = win_q;
    hit_d    = 1'b0;
    foul_d   = 1'b0;
    scorer   = 1'b0;
    s_w      = '0;
    o_w      = '0;
    rule_met = 1'b0;
    sat      = 1'b0;
    if (new_game) begin
      state_d = PLAY;
      sl_d    = '0;
      sr_d    = '0;
      dir_d   = 1'b1;
      win_d   = 1'b0;
    end else if (state_q == PLAY && |press) begin
      // Left wins a same-cycle tie; the right event is simply dropped.
      if (press[0]) begin
        if (ball_at_l) begin
          sl_d = sl_q + 1'b1; dir_d = 1'b1; hit_d = 1'b1; scorer = 1'b0;
        end else begin
          sr_d = sr_q + 1'b1; foul_d = 1'b1; scorer = 1'b1;
        end
      end else begin
        if (ball_at_r) begin
          sr_d = sr_q + 1'b1; dir_d = 1'b0; hit_d = 1'b1; scorer = 1'b1;
        end else begin
          sl_d = sl_q + 1'b1; foul_d = 1'b1; scorer = 1'b0;
        end
      end
      s_w = scorer ? {1'b0, sr_d} : {1'b0, sl_d};
      o_w = scorer ? {1'b0, sl_d} : {1'b0, sr_d};
      sat = (s_w == {1'b0, {SCORE_W{1'b1}}});
`ifdef PONG_WIN_BY_TWO_EN
      rule_met = (s_w >= (SCORE_W+1)'(WIN_SCORE)) && (s_w >= o_w + (SCORE_W+1)'(2));
`else
      rule_met = (s_w >= (SCORE_W+1)'(WIN_SCORE));
`endif
      if (rule_met || sat) begin
        state_d = OVER;
        win_d   = scorer;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= PLAY;
      sl_q    <= '0;
      sr_q    <= '0;
      dir_q   <= 1'b1;
      win_q   <= 1'b0;
      hit_q   <= 1'b0;
      foul_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sl_q    <= sl_d;
      sr_q    <= sr_d;
      dir_q   <= dir_d;
      win_q   <= win_d;
      hit_q   <= hit_d;
      foul_q  <= foul_d;
    end
  end

  assign score_l   = sl_q;
  assign score_r   = sr_q;
  assign dir       = dir_q;
  assign hit       = hit_q;
  assign foul      = foul_q;
  assign game_over = (state_q == OVER);
  assign winner    = win_q;
endmodule
